// File: rtl/nfu_2_accum.sv
// rtl/nfu_2_accum.sv - NFU-2 pipelined per-neuron adder tree plus group accumulator
// Define NFU2_SATURATE_EN to make every tree and accumulate add saturate instead of wrap.
module nfu_2_accum #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int LOG_TN    = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic                         i_first,
  input  logic                         i_last,
  input  logic [Tn*Tn*BIT_WIDTH-1:0]   i_products,
  output logic                         o_valid,
  output logic [Tn*BIT_WIDTH-1:0]      o_nfu2_out,
  output logic                         o_busy,
  output logic [CNT_WIDTH-1:0]         o_count
);

  localparam int MSB = BIT_WIDTH - 1;

  function automatic logic [BIT_WIDTH-1:0] add(input logic [BIT_WIDTH-1:0] a,
                                               input logic [BIT_WIDTH-1:0] b);
    logic [BIT_WIDTH-1:0] s;
    s = a + b;
`ifdef NFU2_SATURATE_EN
    if ((a[MSB] == b[MSB]) && (s[MSB] != a[MSB]))
      s = a[MSB] ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : {1'b0, {(BIT_WIDTH-1){1'b1}}};
`endif
    return s;
  endfunction

  // Level 0 registers the raw products; level l holds Tn>>l partial sums per neuron.
  for (genvar l = 0; l <= LOG_TN; l++) begin : g_lvl
    localparam int W = Tn >> l;
    logic [BIT_WIDTH-1:0] sums [Tn][W];

    if (l == 0) begin : g_in
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int n = 0; n < Tn; n++)
            for (int j = 0; j < W; j++)
              sums[n][j] <= '0;
        end else begin
          for (int n = 0; n < Tn; n++)
            for (int j = 0; j < W; j++)
              sums[n][j] <= i_products[(n*Tn+j)*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int n = 0; n < Tn; n++)
            for (int j = 0; j < W; j++)
              sums[n][j] <= '0;
        end else begin
          for (int n = 0; n < Tn; n++)
            for (int j = 0; j < W; j++)
              sums[n][j] <= add(g_lvl[l-1].sums[n][2*j], g_lvl[l-1].sums[n][2*j+1]);
        end
      end
    end
  end

  logic [LOG_TN:0] v_pipe, f_pipe, l_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      f_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[LOG_TN-1:0], i_valid};
      f_pipe <= {f_pipe[LOG_TN-1:0], i_first & i_valid};
      l_pipe <= {l_pipe[LOG_TN-1:0], i_last & i_valid};
    end
  end

  wire beat_v = v_pipe[LOG_TN];
  wire beat_f = f_pipe[LOG_TN];
  wire beat_l = l_pipe[LOG_TN];

  logic [BIT_WIDTH-1:0] acc      [Tn];
  logic [BIT_WIDTH-1:0] acc_next [Tn];

  always_comb begin
    for (int n = 0; n < Tn; n++)
      acc_next[n] = beat_f ? g_lvl[LOG_TN].sums[n][0]
                           : add(acc[n], g_lvl[LOG_TN].sums[n][0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < Tn; n++)
        acc[n] <= '0;
      o_nfu2_out <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_count    <= '0;
    end else begin
      o_valid <= 1'b0;
      if (beat_v) begin
        if (beat_l) begin
          for (int n = 0; n < Tn; n++) begin
            o_nfu2_out[n*BIT_WIDTH +: BIT_WIDTH] <= acc_next[n];
            acc[n] <= '0;
          end
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
          o_count <= '0;
        end else begin
          for (int n = 0; n < Tn; n++)
            acc[n] <= acc_next[n];
          o_busy <= 1'b1;
          // A new first restarts the count along with the accumulator.
          if (beat_f)
            o_count <= CNT_WIDTH'(1);
          else if (!(&o_count))
            o_count <= o_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nfu_2_accum.sv
// tb/tb_nfu_2_accum.sv - table-driven scoreboard bench for nfu_2_accum
module tb_nfu_2_accum;
  localparam int BW = 16, TN = 16, LOG = 4, CW = 8, LAT = LOG + 1;

  logic clk = 1'b0;
  logic rst_n, i_valid, i_first, i_last;
  logic [TN*TN*BW-1:0] i_products;
  logic o_valid, o_busy;
  logic [TN*BW-1:0] o_nfu2_out;
  logic [CW-1:0] o_count;

  always #5 clk = ~clk;

  nfu_2_accum #(.BIT_WIDTH(BW), .Tn(TN), .LOG_TN(LOG), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
    .i_products(i_products), .o_valid(o_valid), .o_nfu2_out(o_nfu2_out),
    .o_busy(o_busy), .o_count(o_count)
  );

  // Products of neuron n are base+n (or plain base when uni), so a k-beat group
  // gives neuron n the value e0 + 16*n*k.
  typedef struct {
    logic v, f, l, uni;
    logic [15:0] base;
    logic ev;
    logic [15:0] e0;
    int k;
    logic [7:0] cnt;
    logic busy;
  } vec_t;

  typedef struct {
    logic ev;
    logic [15:0] e0;
    int k;
    logic uni;
    logic [7:0] cnt;
    logic busy;
  } exp_t;

  exp_t q[$];
  vec_t tbl[$];
  int checks = 0, failures = 0;
  logic [TN*BW-1:0] held;
  logic [7:0] cur_cnt;
  logic cur_busy;

  task automatic chk(input string name, input logic [TN*BW-1:0] act, input logic [TN*BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TN*BW-1:0] expv(input logic [15:0] e0, input int k, input logic uni);
    logic [TN*BW-1:0] r;
    for (int n = 0; n < TN; n++)
      r[n*BW +: BW] = uni ? e0 : 16'(e0 + 16'(16 * n * k));
    return r;
  endfunction

  task automatic check_out(input exp_t e);
    logic [TN*BW-1:0] ex;
    chk("o_valid", TN*BW'(o_valid), TN*BW'(e.ev));
    if (e.ev) begin
      ex = expv(e.e0, e.k, e.uni);
      chk("o_nfu2_out", o_nfu2_out, ex);
      held = ex;
    end else begin
      chk("hold", o_nfu2_out, held);
    end
    chk("o_count", TN*BW'(o_count), TN*BW'(e.cnt));
    chk("o_busy", TN*BW'(o_busy), TN*BW'(e.busy));
  endtask

  task automatic drive(input logic v, f, l, uni, input logic [15:0] base,
                       input logic ev, input logic [15:0] e0, input int k,
                       input logic [7:0] cnt, input logic busy);
    exp_t e;
    i_valid = v; i_first = f; i_last = l;
    for (int n = 0; n < TN; n++)
      for (int j = 0; j < TN; j++)
        i_products[(n*TN+j)*BW +: BW] = uni ? base : 16'(base + 16'(n));
    e = '{ev, e0, k, uni, cnt, busy};
    q.push_back(e);
    cur_cnt = cnt; cur_busy = busy;
    @(posedge clk); #1;
    if (q.size() > LAT) check_out(q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, cur_cnt, cur_busy);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_valid"}, TN*BW'(o_valid), '0);
    chk({tag, "_out"}, o_nfu2_out, '0);
    chk({tag, "_count"}, TN*BW'(o_count), '0);
    chk({tag, "_busy"}, TN*BW'(o_busy), '0);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 0; i_first = 0; i_last = 0; i_products = '0;
    held = '0; cur_cnt = 0; cur_busy = 0;
    repeat (3) @(posedge clk);
    #1 reset_state("rst");
    @(negedge clk) rst_n = 1'b1;

    //            v f l u base      ev e0        k cnt busy
    tbl.push_back('{1,1,1,0,16'h0001, 1,16'h0010, 1, 0, 0});
    tbl.push_back('{0,0,0,0,16'h0000, 0,16'h0000, 0, 0, 0});
    tbl.push_back('{1,1,0,0,16'h0001, 0,16'h0000, 0, 1, 1});
    tbl.push_back('{1,0,0,0,16'h0001, 0,16'h0000, 0, 2, 1});
    tbl.push_back('{1,0,1,0,16'h0001, 1,16'h0030, 3, 0, 0});
    tbl.push_back('{1,1,0,0,16'h0001, 0,16'h0000, 0, 1, 1});
    tbl.push_back('{1,0,0,0,16'h0001, 0,16'h0000, 0, 2, 1});
    tbl.push_back('{0,1,1,0,16'h0777, 0,16'h0000, 0, 2, 1});
    tbl.push_back('{1,0,1,0,16'h0001, 1,16'h0030, 3, 0, 0});
    tbl.push_back('{1,0,0,0,16'h0002, 0,16'h0000, 0, 1, 1});
    tbl.push_back('{1,0,1,0,16'h0003, 1,16'h0050, 2, 0, 0});
    tbl.push_back('{1,1,0,0,16'h0002, 0,16'h0000, 0, 1, 1});
    tbl.push_back('{1,0,0,0,16'h0002, 0,16'h0000, 0, 2, 1});
    tbl.push_back('{1,1,1,0,16'h0002, 1,16'h0020, 1, 0, 0});
    tbl.push_back('{1,1,1,0,16'h0005, 1,16'h0050, 1, 0, 0});
    tbl.push_back('{1,1,0,0,16'h0007, 0,16'h0000, 0, 1, 1});
    tbl.push_back('{1,0,1,0,16'h0100, 1,16'h1070, 2, 0, 0});
    tbl.push_back('{1,1,1,0,16'h0003, 1,16'h0030, 1, 0, 0});
    tbl.push_back('{1,1,1,0,16'h0004, 1,16'h0040, 1, 0, 0});
`ifdef NFU2_SATURATE_EN
    tbl.push_back('{1,1,1,1,16'h4000, 1,16'h7FFF, 1, 0, 0});
    tbl.push_back('{1,1,1,1,16'hC000, 1,16'h8000, 1, 0, 0});
`else
    tbl.push_back('{1,1,1,1,16'h4000, 1,16'h0000, 1, 0, 0});
    tbl.push_back('{1,1,1,1,16'hC000, 1,16'h0000, 1, 0, 0});
`endif
    tbl.push_back('{1,1,1,0,16'hFFF0, 1,16'hFF00, 1, 0, 0});
    tbl.push_back('{0,0,0,0,16'h0000, 0,16'h0000, 0, 0, 0});

    foreach (tbl[i])
      drive(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].uni, tbl[i].base,
            tbl[i].ev, tbl[i].e0, tbl[i].k, tbl[i].cnt, tbl[i].busy);
    idle(LAT + 1);

    // Beat counter saturates at all-ones on a long group.
    for (int i = 0; i < 260; i++)
      drive(1, i == 0, 0, 1, 16'h0000, 0, 16'h0000, 0, (i + 1 > 255) ? 8'hFF : 8'(i + 1), 1);
    drive(1, 0, 1, 1, 16'h0000, 1, 16'h0000, 1, 0, 0);
    idle(LAT + 1);

    // Reset two cycles after a last beat enters: the in-flight result must vanish.
    drive(1, 1, 1, 0, 16'h0001, 1, 16'h0010, 1, 0, 0);
    i_valid = 0; i_first = 0; i_last = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 reset_state("mid_rst");
    q.delete();
    held = '0; cur_cnt = 0; cur_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 reset_state("in_rst");
    end
    @(negedge clk) rst_n = 1'b1;
    idle(LAT + 2);
    drive(1, 1, 1, 0, 16'h0001, 1, 16'h0010, 1, 0, 0);
    idle(LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nfu_2_accum.md
# nfu_2_accum

NFU-2 stage of the NFU pipeline: for each of Tn output neurons, reduces the Tn synapse products delivered by NFU-1 through a pipelined adder tree and accumulates the tree sums across consecutive input chunks. When the final chunk of a neuron group has been added, it presents Tn partial sums to NFU-3 (sigmoid) with a one-cycle valid pulse. The block is fully pipelined: one beat per cycle, no backpressure.

## Interface
- `BIT_WIDTH`, 16: datapath width, Q6.10 two's complement.
- `Tn`, 16: neurons per beat and products per neuron. Must be a power of 2, ≥ 2.
- `LOG_TN`, 4: log2(Tn). Sets the number of adder-tree stages.
- `CNT_WIDTH`, 8: width of the beat counter.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  beat valid.
- `i_first`  in  1  beat opens a new neuron group. Qualified by `i_valid`.
- `i_last`  in  1  beat closes the group. Qualified by `i_valid`.
- `i_products`  in  Tn*Tn*BIT_WIDTH  product j of neuron n at bits [(n*Tn+j)*BIT_WIDTH +: BIT_WIDTH].
- `o_valid`  out  1  one-cycle pulse: `o_nfu2_out` holds a completed group.
- `o_nfu2_out`  out  Tn*BIT_WIDTH  neuron n sum at bits [n*BIT_WIDTH +: BIT_WIDTH]. Feeds the NFU-3 input.
- `o_busy`  out  1  a group is open: accumulation has started and `i_last` has not yet reached the accumulator.
- `o_count`  out  CNT_WIDTH  number of beats accumulated into the open group.

## Operation
- **Adder tree**
  - Each neuron has a binary tree of LOG_TN levels.
  - Every level is registered.
  - `i_valid`, `i_first` and `i_last` travel in a shift pipeline aligned with the tree data.
  - Bubbles (`i_valid`=0) propagate without effect.
- **Accumulator stage** (one register per neuron). When an aligned beat arrives at the accumulator:
  - If `first`: acc_next = tree_sum. Otherwise: acc_next = acc + tree_sum.
  - If `last`: `o_nfu2_out` <= acc_next, `o_valid`=1, acc <= 0, `o_count` <= 0, `o_busy` <= 0.
  - Otherwise: acc <= acc_next, `o_count` increments (saturating at all-ones), `o_busy` <= 1.
- **Group boundaries**
  - `first` and `last` on the same beat: the output is that beat's tree sum alone.
  - A beat without `first` when no group is open adds onto acc, which is 0 after reset or after a `last`. `first` is therefore optional for the opening beat.
  - `first` arriving while a group is open discards the old acc; no output is produced for the abandoned group.
- **Output holding**: `o_nfu2_out` holds its value until the next `last`.
- **Arithmetic**
  - All adds are BIT_WIDTH wide, with no width growth.
  - Default behaviour is two's-complement wrap (see Configuration).
- **Reset values**: all pipeline registers, acc, `o_nfu2_out`, `o_count` = 0; `o_valid`=0; `o_busy`=0.
- **Reset mid-operation**: in-flight beats are lost, with no output pulse.

## Timing
- Latency: a beat sampled at edge t reaches the accumulator at edge t+LOG_TN. Its result, `o_valid` included, is visible after edge t+LOG_TN+1. That is 5 cycles for the default parameters.
- Throughput: 1 beat/cycle. Back-to-back groups are allowed: `last` on beat k and `first` on beat k+1 both work.
- `o_valid` is never high on consecutive cycles unless consecutive beats carry `last`.
- `o_busy` and `o_count` update on the same edge as acc.

## Configuration
- Macro: `NFU2_SATURATE_EN`.
- Defined: every tree add and accumulate add saturates.
  - Positive overflow gives 0x7FFF.
  - Negative overflow gives 0x8000 (for BIT_WIDTH=16).
- Undefined: adds wrap modulo 2^BIT_WIDTH. This matches the existing integer adders.

## Test plan
1. Reset, then one beat with all products 0x0001 and `first`=`last`=1 → after 5 cycles, `o_valid` pulses once and every neuron reads 0x0010.
2. Three consecutive beats of all-0x0001: `first` on beat 0, `last` on beat 2 → a single `o_valid` pulse, 7 cycles after beat 0, with every neuron at 0x0030. `o_count` reads 1, then 2 while open, then 0.
3. Same as test 2 with an `i_valid`=0 bubble between beats 1 and 2 → same 0x0030 result, delayed one cycle. The bubble has no effect.
4. All products 0x4000, `first`=`last`=1 → 0x0000 without `NFU2_SATURATE_EN`; 0x7FFF with it. All products 0xC000 with the macro defined → 0x8000.
5. Open a group with two beats, then assert `first` on the next beat with `last`, products all 0x0002 → output 0x0020 only, with no pulse for the abandoned group.
6. Assert `rst_n`=0 two cycles after a `last` beat enters → no `o_valid`, all outputs 0. After release, test 1 passes again.
